// File: rtl/uart_tx_stim_pkg.sv
// Shared UART definitions: data width, default divider/FIFO depth and the
// transmitter state encoding used by uart_tx_stim and its FIFO.
package uart_tx_stim_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_DEF_DIV_RATE   = 260;  // 38400 baud at 10 MHz
  localparam int UART_DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Head byte is presented on dout
// combinationally; pushes while full are dropped and latch a sticky overflow.
module uart_tx_fifo
  import uart_tx_stim_pkg::*;
#(
  parameter int DEPTH = UART_DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] din,
  output logic [UART_DATA_W-1:0] dout,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   do_push;
  logic                   do_pop;

  // A push is judged against the pre-edge full flag, so a same-edge pop
  // does not make room for it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array: written only on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and sticky overflow; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_stim.sv
// 8N1 UART transmitter used as a stimulus source for the chip's uart_rx.
// Bytes are queued in uart_tx_fifo and serialised LSB first.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for DIV_RATE cycles
//   ST_DATA  | eight data bits, LSB first, DIV_RATE cycles each
//   ST_STOP  | stop bit (high) for DIV_RATE cycles, tx_end on exit
module uart_tx_stim
  import uart_tx_stim_pkg::*;
#(
  parameter int DIV_RATE   = UART_DEF_DIV_RATE,
  parameter int FIFO_DEPTH = UART_DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_end
);

  localparam int BAUD_W = $clog2(DIV_RATE);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV_RATE - 1);

  tx_state_t              state, state_nxt;
  logic [BAUD_W-1:0]      baud_cnt, baud_nxt;
  logic [2:0]             bit_cnt, bit_nxt;
  logic [UART_DATA_W-1:0] shift_reg, shift_nxt;
  logic                   tx_nxt;
  logic                   tx_end_nxt;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   baud_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .pop      (pop),
    .din      (wr_data),
    .dout     (fifo_dout),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != ST_IDLE);

  // Next-state logic; tx is computed one cycle ahead so the pin comes from a flop.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt + 1'b1;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift_reg;
    tx_nxt     = tx;
    tx_end_nxt = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          tx_nxt    = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_nxt  = '0;
          tx_nxt    = shift_reg[0];
          shift_nxt = {1'b0, shift_reg[UART_DATA_W-1:1]};
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            bit_nxt   = '0;
            tx_nxt    = 1'b1;
            state_nxt = ST_STOP;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            tx_nxt    = shift_reg[0];
            shift_nxt = {1'b0, shift_reg[UART_DATA_W-1:1]};
          end
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_nxt   = '0;
          tx_end_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame in progress and parks the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_end    <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      tx        <= tx_nxt;
      tx_end    <= tx_end_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Scoreboard bench for uart_tx_stim: writers push expected bytes, a line
// monitor decodes every frame on tx and checks bit timing against them.
module tb_uart_tx_stim;

  localparam int DIV  = 260;
  localparam int DIV2 = 2;
  localparam int PER  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx, busy, tx_end;

  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       full2, empty2, overflow2, tx2, busy2, tx_end2;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  time        last_end_t = 0;
  bit         gap_due = 1'b0;
  bit         in_frame = 1'b0;

  uart_tx_stim #(.DIV_RATE(DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .tx(tx), .busy(busy), .tx_end(tx_end)
  );

  uart_tx_stim #(.DIV_RATE(DIV2), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .overflow(overflow2),
    .tx(tx2), .busy(busy2), .tx_end(tx_end2)
  );

  always #(PER/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Writes bytes on consecutive edges; the first n_acc are expected on the line.
  task automatic burst(input logic [7:0] bytes[$], input int n_acc);
    foreach (bytes[i]) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = bytes[i];
      if (i < n_acc) exp_q.push_back(bytes[i]);
    end
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int max_cyc);
    int c = 0;
    while ((exp_q.size() != 0 || in_frame || busy || !empty) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", c < max_cyc, 1);
  endtask

  // Line monitor: decodes each frame and checks every cycle of every bit.
  initial begin : line_mon
    logic       prev_tx;
    logic [9:0] bits;
    logic       bit_ok;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tx = 1'b1;
      end else begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          in_frame = 1'b1;
          if (gap_due) check("start_gap_cycles", 32'(($time - last_end_t) / PER), 1);
          gap_due = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            bits = 10'h200;
          end else begin
            bits = {1'b1, exp_q.pop_front(), 1'b0};
          end
          bit_ok = 1'b1;
          for (int n = 0; n <= 10*DIV; n++) begin
            if (n > 0) @(negedge clk);
            if (reset) break;
            if (n < 10*DIV) begin
              if (tx !== bits[n/DIV] || tx_end !== 1'b0 || busy !== 1'b1) bit_ok = 1'b0;
              if (n % DIV == DIV-1) begin
                check($sformatf("frame_bit%0d_of_%02h", n/DIV, bits[8:1]), bit_ok, 1);
                bit_ok = 1'b1;
              end
            end else begin
              check("tx_end_tx_busy", {tx_end, tx, busy}, 3'b110);
              last_end_t = $time;
              gap_due    = (exp_q.size() != 0);
            end
          end
          in_frame = 1'b0;
        end
        prev_tx = tx;
      end
    end
  end

  initial begin : watchdog
    #(PER*95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int        c;
    int        f;
    int        low_len;
    int        high_len;
    int        te_idx;
    logic      tx2_h[40];
    logic      te2_h[40];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_end", tx_end, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx2", tx2, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0x55, with write-to-start latency
    burst('{8'h55}, 1);
    check("tx_before_start", tx, 1);
    @(negedge clk);
    check("tx_start_latency", tx, 0);
    wait_idle(3000);

    // Back-to-back "ABC"
    burst('{8'h41, 8'h42, 8'h43}, 3);
    wait_idle(9000);

    // Simultaneous push and pop with three bytes queued
    burst('{8'h10}, 1);
    burst('{8'h21, 8'h22, 8'h23}, 3);
    c = 0;
    while (tx_end !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("wait_tx_end_timeout", c < 3000, 1);
    wr_en   = 1'b1;
    wr_data = 8'h24;
    exp_q.push_back(8'h24);
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = 8'hEE;
    check("pushpop_empty", empty, 0);
    check("pushpop_full", full, 0);
    burst('{8'h30, 8'h31, 8'h32, 8'h33, 8'h34}, 5);
    check("pushpop_fill_full", full, 1);
    check("pushpop_fill_ovf", overflow, 0);
    wait_idle(30000);

    // Overflow while a frame is in flight: 0x08 is dropped
    burst('{8'h66}, 1);
    repeat (5) @(negedge clk);
    burst('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 8);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    wait_idle(26000);
    check("ovf_drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);

    // Reset 1000 cycles into a 0xA5 frame with three bytes queued
    burst('{8'hA5}, 1);
    burst('{8'hB1, 8'hB2, 8'hB3}, 3);
    repeat (1000) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    @(negedge clk);
    exp_q.delete();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_empty", empty, 1);
    check("abort_full", full, 0);
    check("abort_overflow", overflow, 0);
    check("abort_tx_end", tx_end, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (3000) @(negedge clk);
    check("post_abort_tx", tx, 1);
    check("post_abort_busy", busy, 0);
    check("post_abort_empty", empty, 1);

    // Minimum divider: 0xFF with DIV_RATE=2
    @(negedge clk);
    wr_en2   = 1'b1;
    wr_data2 = 8'hFF;
    @(negedge clk);
    wr_en2   = 1'b0;
    wr_data2 = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tx2_h[i] = tx2;
      te2_h[i] = tx_end2;
      @(negedge clk);
    end
    f = -1;
    for (int i = 39; i >= 0; i--) if (tx2_h[i] === 1'b0) f = i;
    low_len = 0;
    high_len = 0;
    te_idx = -1;
    for (int i = 39; i >= 0; i--) if (te2_h[i] === 1'b1) te_idx = i;
    if (f >= 0) begin
      for (int i = f; i < 40 && tx2_h[i] === 1'b0; i++) low_len++;
      for (int i = f + low_len; i < 40 && tx2_h[i] === 1'b1 && te2_h[i] !== 1'b1; i++) high_len++;
    end
    check("div2_latency", f, 1);
    check("div2_low_len", low_len, 2);
    check("div2_high_len", high_len, 18);
    check("div2_tx_end_offset", te_idx - f, 20);
    check("div2_tx_end_width", (te_idx >= 0 && te_idx < 39) ? te2_h[te_idx+1] : 1'b1, 0);
    check("div2_final_busy", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
